sips4_input_cond: RTL and testbench

SIPS4_INPUT_COND -- requirements
Module: sips4_input_cond

---
 rtl/sips4_input_cond.sv | 125 ++++++++++++
 tb/tb_sips4_input_cond.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sips4_input_cond.sv
// Input conditioning for four slide switches and two active-low push-buttons:
// per-channel synchronizer and debounce FSM, plus press strobes and sticky press flags.
module sips4_input_cond #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] slide_raw,
    input  logic [1:0] button_raw,
    output logic [3:0] slide,
    output logic [1:0] button,
    output logic [1:0] press_pulse,
    output logic [1:0] press_latch,
    input  logic [1:0] clear_latch
);

    localparam int NCH = 6;
    localparam int CW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Idle level per channel: slides rest low, active-low buttons rest high.
    localparam logic [NCH-1:0] IDLE = 6'b11_0000;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_db;
    logic [1:0]     w_btn_next;
    logic [1:0]     r_pulse;
    logic [1:0]     r_latch;

    assign w_raw = {button_raw, slide_raw};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   w_sync;
            state_t                 r_state;
            state_t                 w_state_next;
            logic [CW-1:0]          r_cnt;
            logic [CW-1:0]          w_cnt_next;
            logic                   r_out;
            logic                   w_out_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{IDLE[gi]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_out_next   = r_out;
                case (r_state)
                    ST_STABLE: begin
                        if (w_sync != r_out) begin
                            w_state_next = ST_CHANGING;
                            w_cnt_next   = CW'(1);
                        end else begin
                            w_cnt_next   = '0;
                        end
                    end
                    ST_CHANGING: begin
                        if (w_sync == r_out) begin
                            w_state_next = ST_STABLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            w_state_next = ST_STABLE;
                            w_cnt_next   = '0;
                            w_out_next   = w_sync;
                        end else begin
                            w_cnt_next   = r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        w_state_next = ST_STABLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_out   <= IDLE[gi];
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_out   <= w_out_next;
                end
            end

            assign w_db[gi] = r_out;

            // Buttons expose their next value so the press strobe lands with the debounced edge.
            if (gi >= NCH - 2) begin : g_btn
                assign w_btn_next[gi-(NCH-2)] = w_out_next;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse <= '0;
            r_latch <= '0;
        end else begin
            r_pulse <= w_db[5:4] & ~w_btn_next;
            r_latch <= r_pulse | (r_latch & ~clear_latch);
        end
    end

    assign slide       = w_db[3:0];
    assign button      = w_db[5:4];
    assign press_pulse = r_pulse;
    assign press_latch = r_latch;

endmodule

// File: tb/tb_sips4_input_cond.sv
// Scoreboard bench for sips4_input_cond with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// stimulus queues each expected output change with its cycle, a monitor checks every change.
module tb_sips4_input_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] slide_raw;
    logic [1:0] button_raw;
    logic [3:0] slide;
    logic [1:0] button;
    logic [1:0] press_pulse;
    logic [1:0] press_latch;
    logic [1:0] clear_latch;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev_vec;

    typedef struct {
        int         when;
        logic [9:0] vec;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    sips4_input_cond #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .slide_raw  (slide_raw),
        .button_raw (button_raw),
        .slide      (slide),
        .button     (button),
        .press_pulse(press_pulse),
        .press_latch(press_latch),
        .clear_latch(clear_latch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int dly, input logic [3:0] s, input logic [1:0] b,
                        input logic [1:0] p, input logic [1:0] l, input string nm);
        exp_t e;
        e.when = cyc + dly;
        e.vec  = {s, b, p, l};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    always @(negedge clk) begin
        logic [9:0] vec;
        exp_t e;
        vec = {slide, button, press_pulse, press_latch};
        if (mon_en && vec !== prev_vec) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, vec);
            end else begin
                e = exp_q.pop_front();
                if (vec !== e.vec || cyc != e.when) begin
                    bad++;
                    $display("FAIL %s got=%b@%0d want=%b@%0d", e.name, vec, cyc, e.vec, e.when);
                end else begin
                    $display("ok %s vec=%b cyc=%0d", e.name, vec, cyc);
                end
            end
            prev_vec = vec;
        end
    end

    initial begin
        rst         = 1'b1;
        slide_raw   = 4'b0000;
        button_raw  = 2'b11;
        clear_latch = 2'b00;
        step(3);

        total++;
        if ({slide, button, press_pulse, press_latch} !== 10'b0000_11_00_00) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b",
                     {slide, button, press_pulse, press_latch}, 10'b0000_11_00_00);
        end else begin
            $display("ok reset_state");
        end
        prev_vec = {slide, button, press_pulse, press_latch};
        mon_en   = 1'b1;
        rst      = 1'b0;
        step(2);

        // Slide step 0000 -> 0101
        slide_raw = 4'b0101;
        push(6, 4'b0101, 2'b11, 2'b00, 2'b00, "slide_0101");
        step(10);

        // Press button 0: pulse with the debounced edge, latch one cycle later
        button_raw = 2'b10;
        push(6, 4'b0101, 2'b10, 2'b01, 2'b00, "press0_pulse");
        push(7, 4'b0101, 2'b10, 2'b00, 2'b01, "press0_latch");
        step(10);
        clear_latch = 2'b01;
        push(1, 4'b0101, 2'b10, 2'b00, 2'b00, "clear0");
        step(1);
        clear_latch = 2'b00;
        step(3);

        // Button 1 bounces one cycle at a time: nothing may change
        button_raw = 2'b00; step(1);
        button_raw = 2'b10; step(1);
        button_raw = 2'b00; step(1);
        button_raw = 2'b10; step(12);

        // Release button 0: no pulse
        button_raw = 2'b11;
        push(6, 4'b0101, 2'b11, 2'b00, 2'b00, "release0");
        step(10);

        // Clear held across a press: set wins, then cleared next cycle
        clear_latch = 2'b01;
        button_raw  = 2'b10;
        push(6, 4'b0101, 2'b10, 2'b01, 2'b00, "held_clr_pulse");
        push(7, 4'b0101, 2'b10, 2'b00, 2'b01, "held_clr_set");
        push(8, 4'b0101, 2'b10, 2'b00, 2'b00, "held_clr_clear");
        step(10);
        clear_latch = 2'b00;
        button_raw  = 2'b11;
        push(6, 4'b0101, 2'b11, 2'b00, 2'b00, "release0_b");
        step(10);

        // Reset two cycles into a slide[3] debounce
        slide_raw = 4'b1101;
        step(4);
        rst = 1'b1;
        push(1, 4'b0000, 2'b11, 2'b00, 2'b00, "reset_mid_count");
        step(1);
        total++;
        if (slide[3] !== 1'b0) begin
            bad++;
            $display("FAIL slide3_in_reset got=%b want=0", slide[3]);
        end else begin
            $display("ok slide3_in_reset");
        end
        step(1);
        rst = 1'b0;
        push(6, 4'b1101, 2'b11, 2'b00, 2'b00, "slide3_after_reset");
        step(10);

        // Button held pressed through reset
        button_raw = 2'b10;
        rst        = 1'b1;
        push(1, 4'b0000, 2'b11, 2'b00, 2'b00, "reset_again");
        step(2);
        rst = 1'b0;
        push(6, 4'b1101, 2'b10, 2'b01, 2'b00, "held_rst_pulse");
        push(7, 4'b1101, 2'b10, 2'b00, 2'b01, "held_rst_latch");
        step(10);
        clear_latch = 2'b01;
        push(1, 4'b1101, 2'b10, 2'b00, 2'b00, "clear0_final");
        step(1);
        clear_latch = 2'b00;
        step(5);

        mon_en = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0 next=%s",
                     exp_q.size(), exp_q[0].name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
